// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the sfifo read-side streaming adapter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fifo_rd_stream_pkg;

  // Buffer operation for one clock edge, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

  // Room for another read once in-flight and departing words are counted.
  // A pop only happens with occ >= 1, so the 3-bit difference never wraps.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] level;
    level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return level < 3'd2;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order word buffer; head entry is presented directly as the output word.
// Latency: a pushed word is visible on ent0_o the cycle after the push edge when the buffer was empty.
// Backpressure: none internally; the caller must never push into a full buffer without a same-cycle pop.
module skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] ent0_o
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  buf_op_e          op;

  assign op     = buf_op_e'({push_i, pop_i});
  assign occ_o  = occ_q;
  assign ent0_o = ent0_q;

  // Next-state: shift on pop, fill the first free slot on push, keep order on both.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case (op)
      OP_PUSH: begin
        if (occ_q == 2'd0) ent0_d = din_i;
        else               ent1_d = din_i;
        occ_d = occ_q + 2'd1;
      end
      OP_POP: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      OP_BOTH: begin
        if (occ_q == 2'd1) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Buffer state registers; reset clears contents so the idle output word is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  // The upstream credit logic is what keeps the buffer from overflowing.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && !pop_i && occ_q == 2'd2));

  // Occupancy can never leave the 0..2 range.
  assert property (@(posedge clk) disable iff (!rst_n) occ_q != 2'd3);

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an sfifo read port into a valid/ready stream at up to one word per clock.
// Latency: rinc in cycle N -> word in buffer and m_valid high from cycle N+2.
// Backpressure: m_ready low holds the head word; reads are issued only while buffer credit remains.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] rd_cnt
);

  logic             inflight_q;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             pop;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign rd_cnt  = rd_cnt_q;

  // m_ready feeds rinc combinationally so a departing word frees its slot in the same cycle.
  assign fifo_rinc = rst_n & en & ~fifo_rempty & credit_ok(occ, inflight_q, pop);

  // Delivered-word counter, free-running and wrapping.
  always_comb begin
    rd_cnt_d = rd_cnt_q + CNT_W'(pop);
  end

  // An accepted read lands on fifo_rdata one cycle later; reset drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      inflight_q <= fifo_rinc;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .pop_i  (pop),
    .din_i  (fifo_rdata),
    .occ_o  (occ),
    .ent0_o (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: behavioural sfifo plus a write-order scoreboard around fifo_rd_stream.
// Latency: n/a.
// Backpressure: consumer ready and read enable are driven directed and randomly.
module tb_fifo_rd_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             fifo_rempty;
  logic             fifo_rinc;
  logic [WIDTH-1:0] fifo_rdata;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       occ;
  logic [CNT_W-1:0] rd_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .fifo_rdata  (fifo_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .occ         (occ),
    .rd_cnt      (rd_cnt)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural sfifo (DEPTH 16, registered read) ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  int               wp = 0, rp = 0, fcnt = 0, fc_nxt;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] exp_q [$];

  assign fifo_rempty = (fcnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 0; rp <= 0; fcnt <= 0; fifo_rdata <= '0;
      exp_q.delete();
    end else begin
      fc_nxt = fcnt;
      if (fifo_rinc && fcnt > 0) begin
        fifo_rdata <= mem[rp];
        rp <= (rp + 1) % DEPTH;
        fc_nxt--;
      end
      if (wr_en && fcnt < DEPTH) begin
        mem[wp] <= wr_data;
        wp <= (wp + 1) % DEPTH;
        fc_nxt++;
        exp_q.push_back(wr_data);
      end
      fcnt <= fc_nxt;
    end
  end

  // ---------------- monitor: samples 2 time units after each falling edge ----------------
  int               exp_cnt = 0;
  int               pops = 0, rinc_seen = 0, cyc = 0;
  int               run = 0, max_run = 0;
  int               first_rinc = -1, first_valid = -1;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] hold_dat = '0;

  initial forever begin
    @(negedge clk); #2;
    cyc++;
    if (!rst_n) begin
      hold = 1'b0;
      run  = 0;
      continue;
    end
    chk("occ_le2", occ <= 2'd2, 1'b1);
    if (hold) begin
      chk("hold_valid", m_valid, 1'b1);
      chk("hold_data", m_data, hold_dat);
    end
    if (fifo_rinc) begin
      rinc_seen++;
      if (first_rinc < 0) first_rinc = cyc;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) begin
      chk("pop_has_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("pop_data", m_data, exp_q.pop_front());
      chk("rd_cnt_track", rd_cnt, exp_cnt[15:0]);
      exp_cnt = (exp_cnt + 1) & 32'hFFFF;
      pops++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    hold     = m_valid && !m_ready;
    hold_dat = m_data;
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && occ == 2'd0 && fcnt == 0) break;
      @(negedge clk);
    end
    chk(tag, exp_q.size() + fcnt + occ, 0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    exp_cnt = 0;
    pops    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] first_w;
  int               written;

  initial begin
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    en = 1'b1;
    do_reset();
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_occ", occ, 2'd0);
    chk("rst_rd_cnt", rd_cnt, 16'd0);
    chk("rst_m_data", m_data, 8'h00);
    @(negedge clk);

    // 1: four words back-to-back with consumer always ready
    m_ready = 1'b1; first_rinc = -1; first_valid = -1; max_run = 0;
    for (int i = 0; i < 4; i++) write_word(8'h11 + 8'(i));
    wait_drain("s1_drain", 50);
    chk("s1_latency", first_valid - first_rinc, 2);
    chk("s1_back_to_back", max_run, 4);
    chk("s1_rd_cnt", rd_cnt, 16'd4);

    // 2: sixteen words while consumer stalls, then full-rate drain
    m_ready = 1'b0; rinc_seen = 0; pops = 0;
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] w;
      w = 8'($urandom);
      if (i == 0) first_w = w;
      write_word(w);
    end
    repeat (10) @(negedge clk);
    #1;
    chk("s2_occ_full", occ, 2'd2);
    chk("s2_head_held", m_data, first_w);
    chk("s2_rinc_pulses", rinc_seen, 2);
    max_run = 0;
    m_ready = 1'b1;
    wait_drain("s2_drain", 100);
    chk("s2_no_bubble", max_run, 16);
    chk("s2_pops", pops, 16);

    // 3: eight queued words, consumer ready alternating 1010..
    m_ready = 1'b0; pops = 0;
    for (int i = 0; i < 8; i++) write_word(8'($urandom));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      m_ready = ~m_ready;
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_drain("s3_drain", 50);
    chk("s3_pops", pops, 8);

    // 4: read enable off with data waiting; buffered words still drain
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(8'($urandom));
    repeat (4) @(negedge clk);
    en = 1'b0; rinc_seen = 0; pops = 0;
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    m_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("s4_no_rinc", rinc_seen, 0);
    chk("s4_occ_drained", occ, 2'd0);
    chk("s4_fifo_left", fcnt, 5);
    en = 1'b1;
    wait_drain("s4_drain", 50);
    chk("s4_pops", pops, 7);

    // random: ready, enable and writes all randomized
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      if (($urandom % 2) == 1 && fcnt < DEPTH - 2) write_word(8'($urandom));
      else @(negedge clk);
    end
    en = 1'b1; m_ready = 1'b1;
    wait_drain("rnd_drain", 100);

    // 5: reset with a full-ish buffer and a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    repeat (4) @(negedge clk);
    #1;
    chk("s5_occ_before", occ, 2'd2);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; exp_cnt = 0; pops = 0;
    #1;
    chk("s5_m_valid", m_valid, 1'b0);
    chk("s5_occ", occ, 2'd0);
    chk("s5_rd_cnt", rd_cnt, 16'd0);
    chk("s5_rinc", fifo_rinc, 1'b0);
    chk("s5_m_data", m_data, 8'h00);
    chk("s5_no_x", 32'($isunknown({m_valid, occ, rd_cnt, fifo_rinc, m_data})), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("s5_after_release", m_valid, 1'b0);

    // 6: 65536 deliveries make rd_cnt wrap back to zero
    @(negedge clk);
    m_ready = 1'b1; en = 1'b1; pops = 0; written = 0;
    for (int i = 0; i < 70000 && written < 65536; i++) begin
      if (fcnt < 8) begin
        write_word(8'($urandom));
        written++;
      end else begin
        @(negedge clk);
      end
    end
    wait_drain("s6_drain", 100);
    chk("s6_pops", pops, 65536);
    chk("s6_rd_cnt_wrap", rd_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
